// File: rtl/sde_c2h_arb_pkg.sv
// Shared types and the round-robin pick helper for the SDE C2H AXI-Stream arbiter.
package sde_c2h_arb_pkg;

  localparam int SDE_C2H_ARB_MAX_SRC = 8;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_PKT = 1'b1} arb_state_t;

  // First requester strictly after ptr, wrapping modulo num; returns ptr when nobody requests.
  function automatic logic [2:0] rr_pick(input logic [SDE_C2H_ARB_MAX_SRC-1:0] req,
                                         input logic [2:0] ptr,
                                         input int num);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= SDE_C2H_ARB_MAX_SRC; k++) begin
      idx = (int'(ptr) + k) % num;
      if (!found && (k <= num) && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sde_axis_out_reg.sv
// Single-entry AXI-Stream register stage; accepts a new beat whenever it is empty or draining.
module sde_axis_out_reg #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64,
  parameter int USER_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic [USER_W-1:0] in_user,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic [USER_W-1:0] out_user,
  output logic              out_last,
  input  logic              out_ready
);

  logic load;

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Payload is only meaningful while out_valid is high, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      out_data <= in_data;
      out_keep <= in_keep;
      out_user <= in_user;
      out_last <= in_last;
    end
  end

endmodule

// File: rtl/sde_c2h_axis_arb.sv
// Packet-level round-robin arbiter merging NUM_SRC AXI-Stream sources onto the SDE C2H channel.
// Optional per-source packet counters are enabled with `define SDE_C2H_ARB_STATS_EN.
module sde_c2h_axis_arb
  import sde_c2h_arb_pkg::*;
#(
  parameter int NUM_SRC         = 4,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int USER_BIT_WIDTH  = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_arb_en,
  input  logic [NUM_SRC-1:0]                     cfg_src_mask,
  input  logic [NUM_SRC-1:0]                     src_axis_valid,
  input  logic [NUM_SRC*AXIS_DATA_WIDTH-1:0]     src_axis_data,
  input  logic [NUM_SRC*AXIS_DATA_WIDTH/8-1:0]   src_axis_keep,
  input  logic [NUM_SRC*USER_BIT_WIDTH-1:0]      src_axis_user,
  input  logic [NUM_SRC-1:0]                     src_axis_last,
  output logic [NUM_SRC-1:0]                     src_axis_ready,
  output logic                                   c2h_axis_valid,
  output logic [AXIS_DATA_WIDTH-1:0]             c2h_axis_data,
  output logic [AXIS_DATA_WIDTH/8-1:0]           c2h_axis_keep,
  output logic [USER_BIT_WIDTH-1:0]              c2h_axis_user,
  output logic                                   c2h_axis_last,
  input  logic                                   c2h_axis_ready,
  output logic                                   arb_busy,
  output logic [$clog2(NUM_SRC)-1:0]             arb_cur_src
`ifdef SDE_C2H_ARB_STATS_EN
  ,
  input  logic                                   cfg_clr_pkt_cnt,
  output logic [NUM_SRC*32-1:0]                  arb_src_pkt_cnt
`endif
);

  localparam int SRC_W  = $clog2(NUM_SRC);
  localparam int KEEP_W = AXIS_DATA_WIDTH / 8;

  localparam logic [0:0] ST_IDLE = 1'(ARB_IDLE);
  localparam logic [0:0] ST_PKT  = 1'(ARB_PKT);

  logic [0:0]                     state;
  logic [SRC_W-1:0]               cur_src;
  logic [SRC_W-1:0]               rr_ptr;
  logic [SRC_W-1:0]               winner;
  logic [SDE_C2H_ARB_MAX_SRC-1:0] req_ext;
  logic                           any_req;
  logic                           sel_valid;
  logic                           sel_last;
  logic [AXIS_DATA_WIDTH-1:0]     sel_data;
  logic [KEEP_W-1:0]              sel_keep;
  logic [USER_BIT_WIDTH-1:0]      sel_user;
  logic                           out_ready_int;
  logic                           accept;

  always_comb begin
    req_ext = '0;
    req_ext[NUM_SRC-1:0] = src_axis_valid & cfg_src_mask;
  end

  assign any_req = |req_ext;
  assign winner  = SRC_W'(rr_pick(req_ext, 3'(rr_ptr), NUM_SRC));

  assign sel_valid = (state == ST_PKT) && src_axis_valid[cur_src];
  assign sel_last  = src_axis_last[cur_src];
  assign sel_data  = src_axis_data[int'(cur_src)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
  assign sel_keep  = src_axis_keep[int'(cur_src)*KEEP_W +: KEEP_W];
  assign sel_user  = src_axis_user[int'(cur_src)*USER_BIT_WIDTH +: USER_BIT_WIDTH];
  assign accept    = sel_valid && out_ready_int;

  // Only the granted source sees ready, and only while the output stage can take a beat.
  always_comb begin
    src_axis_ready = '0;
    if (state == ST_PKT) begin
      src_axis_ready[cur_src] = out_ready_int;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cur_src <= '0;
      rr_ptr  <= SRC_W'(NUM_SRC - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_arb_en && any_req) begin
            state   <= ST_PKT;
            cur_src <= winner;
            rr_ptr  <= winner;
          end
        end
        ST_PKT: begin
          if (accept && sel_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign arb_busy    = (state == ST_PKT);
  assign arb_cur_src = cur_src;

  sde_axis_out_reg #(
    .DATA_W (AXIS_DATA_WIDTH),
    .KEEP_W (KEEP_W),
    .USER_W (USER_BIT_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (sel_valid),
    .in_data   (sel_data),
    .in_keep   (sel_keep),
    .in_user   (sel_user),
    .in_last   (sel_last),
    .in_ready  (out_ready_int),
    .out_valid (c2h_axis_valid),
    .out_data  (c2h_axis_data),
    .out_keep  (c2h_axis_keep),
    .out_user  (c2h_axis_user),
    .out_last  (c2h_axis_last),
    .out_ready (c2h_axis_ready)
  );

`ifdef SDE_C2H_ARB_STATS_EN
  logic [31:0] pkt_cnt [NUM_SRC];

  // Clear wins over a same-cycle packet completion.
  always_ff @(posedge clk) begin
    if (rst || cfg_clr_pkt_cnt) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        pkt_cnt[i] <= '0;
      end
    end else if (accept && sel_last) begin
      pkt_cnt[cur_src] <= pkt_cnt[cur_src] + 32'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      arb_src_pkt_cnt[i*32 +: 32] = pkt_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_sde_c2h_axis_arb.sv
// Self-checking bench for sde_c2h_axis_arb: directed scenarios plus randomized traffic
// checked against a beat/packet-level reference model.
module tb_sde_c2h_axis_arb;

  localparam int NUM_SRC = 4;
  localparam int DW      = 32;
  localparam int KW      = DW / 8;
  localparam int UW      = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    int    cyc;
    beat_t beat;
  } out_rec_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    cfg_arb_en;
  logic [NUM_SRC-1:0]      cfg_src_mask;
  logic [NUM_SRC-1:0]      src_axis_valid;
  logic [NUM_SRC*DW-1:0]   src_axis_data;
  logic [NUM_SRC*KW-1:0]   src_axis_keep;
  logic [NUM_SRC*UW-1:0]   src_axis_user;
  logic [NUM_SRC-1:0]      src_axis_last;
  logic [NUM_SRC-1:0]      src_axis_ready;
  logic                    c2h_axis_valid;
  logic [DW-1:0]           c2h_axis_data;
  logic [KW-1:0]           c2h_axis_keep;
  logic [UW-1:0]           c2h_axis_user;
  logic                    c2h_axis_last;
  logic                    c2h_axis_ready;
  logic                    arb_busy;
  logic [1:0]              arb_cur_src;
`ifdef SDE_C2H_ARB_STATS_EN
  logic                    cfg_clr_pkt_cnt;
  logic [NUM_SRC*32-1:0]   arb_src_pkt_cnt;
  bit                      clrOnLast;
`endif

  always #5 clk = ~clk;

  sde_c2h_axis_arb #(
    .NUM_SRC         (NUM_SRC),
    .AXIS_DATA_WIDTH (DW),
    .USER_BIT_WIDTH  (UW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_arb_en      (cfg_arb_en),
    .cfg_src_mask    (cfg_src_mask),
    .src_axis_valid  (src_axis_valid),
    .src_axis_data   (src_axis_data),
    .src_axis_keep   (src_axis_keep),
    .src_axis_user   (src_axis_user),
    .src_axis_last   (src_axis_last),
    .src_axis_ready  (src_axis_ready),
    .c2h_axis_valid  (c2h_axis_valid),
    .c2h_axis_data   (c2h_axis_data),
    .c2h_axis_keep   (c2h_axis_keep),
    .c2h_axis_user   (c2h_axis_user),
    .c2h_axis_last   (c2h_axis_last),
    .c2h_axis_ready  (c2h_axis_ready),
    .arb_busy        (arb_busy),
    .arb_cur_src     (arb_cur_src)
`ifdef SDE_C2H_ARB_STATS_EN
    ,
    .cfg_clr_pkt_cnt (cfg_clr_pkt_cnt),
    .arb_src_pkt_cnt (arb_src_pkt_cnt)
`endif
  );

  int          nChecks = 0;
  int          nFail   = 0;
  int          cyc;
  beat_t       srcQ[NUM_SRC][$];
  out_rec_t    outLog[$];
  int          grantLog[$];
  int          mGrant;
  int          mPtr;
  logic        mOutValid;
  beat_t       mOutBeat;
  int unsigned mCnt[NUM_SRC];
  logic        prevValid;
  logic        prevReady;
  logic        prevBusy;
  beat_t       prevBeat;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic beat_t obsBeat();
    beat_t b;
    b.data = c2h_axis_data;
    b.keep = c2h_axis_keep;
    b.user = c2h_axis_user;
    b.last = c2h_axis_last;
    return b;
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int i = 0; i < NUM_SRC; i++) n += srcQ[i].size();
    return n;
  endfunction

  task automatic addPacket(input int s, input int len, input bit seqData);
    beat_t x;
    for (int b = 0; b < len; b++) begin
      x.data = seqData ? DW'(b) : DW'($urandom);
      x.keep = KW'($urandom_range(1, 15));
      x.user = UW'(s);
      x.last = (b == len - 1);
      srcQ[s].push_back(x);
    end
  endtask

  // Each source presents the head of its queue; rndGap randomly drops valid for a cycle.
  task automatic applyStimulus(input bit rndGap);
    beat_t b;
    for (int i = 0; i < NUM_SRC; i++) begin
      b = '0;
      if (srcQ[i].size() > 0) b = srcQ[i][0];
      src_axis_valid[i]         = (srcQ[i].size() > 0) && !(rndGap && ($urandom_range(0, 3) == 0));
      src_axis_data[i*DW +: DW] = b.data;
      src_axis_keep[i*KW +: KW] = b.keep;
      src_axis_user[i*UW +: UW] = b.user;
      src_axis_last[i]          = b.last;
    end
  endtask

  // One clock: drive, compare DUT against the model, advance the model, cross the edge.
  task automatic step(input bit rndGap, input bit rndRdy);
    logic [NUM_SRC-1:0] expRdy;
    int   acc;
    int   idx;
    bit   wasIdle;
    bit   lastBeat;
    bit   hs;
    cyc++;
    applyStimulus(rndGap);
    c2h_axis_ready = rndRdy ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    expRdy = '0;
    if (mGrant >= 0 && (!mOutValid || c2h_axis_ready)) expRdy[mGrant] = 1'b1;
    checkOutput("busy", 64'(arb_busy), 64'(mGrant >= 0));
    if (mGrant >= 0) checkOutput("cur_src", 64'(arb_cur_src), 64'(mGrant));
    checkOutput("src_ready", 64'(src_axis_ready), 64'(expRdy));
    checkOutput("c2h_valid", 64'(c2h_axis_valid), 64'(mOutValid));
    if (mOutValid) checkOutput("c2h_beat", 64'(obsBeat()), 64'(mOutBeat));
    if (prevValid && !prevReady)
      checkOutput("stall_stable", 64'({c2h_axis_valid, obsBeat()}), 64'({1'b1, prevBeat}));
`ifdef SDE_C2H_ARB_STATS_EN
    for (int i = 0; i < NUM_SRC; i++)
      checkOutput($sformatf("pkt_cnt%0d", i), 64'(arb_src_pkt_cnt[i*32 +: 32]), 64'(mCnt[i]));
`endif
    if (arb_busy && !prevBusy) grantLog.push_back(int'(arb_cur_src));
    if (c2h_axis_valid && c2h_axis_ready) outLog.push_back('{cyc, obsBeat()});
    prevValid = c2h_axis_valid;
    prevReady = c2h_axis_ready;
    prevBusy  = arb_busy;
    prevBeat  = obsBeat();

    wasIdle  = (mGrant < 0);
    hs       = mOutValid && c2h_axis_ready;
    lastBeat = 1'b0;
    acc      = -1;
    if (mGrant >= 0 && expRdy[mGrant] && src_axis_valid[mGrant]) acc = mGrant;
    if (acc >= 0) begin
      lastBeat  = srcQ[acc][0].last;
      mOutBeat  = srcQ[acc].pop_front();
      mOutValid = 1'b1;
      if (lastBeat) mGrant = -1;
    end else if (hs) begin
      mOutValid = 1'b0;
    end
`ifdef SDE_C2H_ARB_STATS_EN
    if (clrOnLast && acc == 3 && lastBeat) begin
      cfg_clr_pkt_cnt = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) mCnt[i] = 0;
    end else if (acc >= 0 && lastBeat) begin
      mCnt[acc]++;
    end
`endif
    // Round robin: first eligible requester after the previous winner, wrapping.
    if (wasIdle && cfg_arb_en) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        idx = (mPtr + k) % NUM_SRC;
        if (mGrant < 0 && src_axis_valid[idx] && cfg_src_mask[idx]) mGrant = idx;
      end
      if (mGrant >= 0) mPtr = mGrant;
    end
    @(posedge clk);
    @(negedge clk);
`ifdef SDE_C2H_ARB_STATS_EN
    cfg_clr_pkt_cnt = 1'b0;
`endif
  endtask

  task automatic runUntilIdle(input int budget, input bit rndGap, input bit rndRdy);
    int n;
    n = 0;
    while ((pending() > 0 || mGrant >= 0 || mOutValid) && n < budget) begin
      step(rndGap, rndRdy);
      n++;
    end
    if (pending() > 0 || mGrant >= 0 || mOutValid) checkOutput("drain_timeout", 64'(1), 64'(0));
  endtask

  task automatic doReset();
    rst            = 1'b1;
    cfg_arb_en     = 1'b1;
    cfg_src_mask   = '1;
    c2h_axis_ready = 1'b1;
    src_axis_valid = '0;
    src_axis_data  = '0;
    src_axis_keep  = '0;
    src_axis_user  = '0;
    src_axis_last  = '0;
`ifdef SDE_C2H_ARB_STATS_EN
    cfg_clr_pkt_cnt = 1'b0;
    clrOnLast       = 1'b0;
`endif
    for (int i = 0; i < NUM_SRC; i++) srcQ[i].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 64'(arb_busy), 64'(0));
    checkOutput("rst_cur_src", 64'(arb_cur_src), 64'(0));
    checkOutput("rst_src_ready", 64'(src_axis_ready), 64'(0));
    checkOutput("rst_c2h_valid", 64'(c2h_axis_valid), 64'(0));
`ifdef SDE_C2H_ARB_STATS_EN
    checkOutput("rst_pkt_cnt", 64'(arb_src_pkt_cnt), 64'(0));
`endif
    rst       = 1'b0;
    mGrant    = -1;
    mPtr      = NUM_SRC - 1;
    mOutValid = 1'b0;
    mOutBeat  = '0;
    for (int i = 0; i < NUM_SRC; i++) mCnt[i] = 0;
    prevValid = 1'b0;
    prevReady = 1'b1;
    prevBusy  = 1'b0;
    prevBeat  = '0;
    outLog.delete();
    grantLog.delete();
    cyc = 0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt[NUM_SRC];
    int total;
    int s;
    int l;

    // Two sources after reset: src0 first at cycles 3-5, src2 after one bubble.
    doReset();
    addPacket(0, 3, 0);
    addPacket(2, 3, 0);
    runUntilIdle(50, 0, 0);
    checkOutput("t1_beats", 64'(outLog.size()), 64'(6));
    if (outLog.size() == 6) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput("t1_src0_cyc", 64'(outLog[i].cyc), 64'(3 + i));
        checkOutput("t1_src0_user", 64'(outLog[i].beat.user), 64'(0));
      end
      checkOutput("t1_src2_cyc", 64'(outLog[3].cyc), 64'(7));
      checkOutput("t1_src2_user", 64'(outLog[3].beat.user), 64'(2));
    end
    checkOutput("t1_grants", 64'(grantLog.size()), 64'(2));
    if (grantLog.size() == 2) checkOutput("t1_grant_order", 64'({grantLog[0], grantLog[1]}), 64'({32'd0, 32'd2}));

    // All sources busy with single-beat packets: strict rotation and equal share.
    doReset();
    for (int p = 0; p < 10; p++) for (int i = 0; i < NUM_SRC; i++) addPacket(i, 1, 0);
    runUntilIdle(200, 0, 0);
    checkOutput("t2_grants", 64'(grantLog.size()), 64'(40));
    if (grantLog.size() >= 5) for (int i = 0; i < 5; i++) checkOutput("t2_order", 64'(grantLog[i]), 64'(i % 4));
    for (int i = 0; i < NUM_SRC; i++) cnt[i] = 0;
    foreach (outLog[i]) cnt[outLog[i].beat.user]++;
    for (int i = 0; i < NUM_SRC; i++) checkOutput($sformatf("t2_share%0d", i), 64'(cnt[i]), 64'(10));

    // Random downstream backpressure over a 5-beat packet carrying 0..4.
    doReset();
    addPacket(1, 5, 1);
    runUntilIdle(200, 0, 1);
    checkOutput("t3_beats", 64'(outLog.size()), 64'(5));
    foreach (outLog[i]) checkOutput("t3_data", 64'(outLog[i].beat.data), 64'(i));

    // Masked source never sees ready; unmasking mid-packet waits for the packet to end.
    doReset();
    cfg_src_mask = 4'b1011;
    addPacket(2, 3, 0);
    repeat (4) begin
      step(0, 0);
      checkOutput("t4_src2_ready", 64'(src_axis_ready[2]), 64'(0));
      checkOutput("t4_idle", 64'(arb_busy), 64'(0));
    end
    addPacket(1, 4, 0);
    repeat (3) begin
      step(0, 0);
      checkOutput("t4_src2_ready", 64'(src_axis_ready[2]), 64'(0));
    end
    cfg_src_mask = 4'hF;
    runUntilIdle(60, 0, 0);
    checkOutput("t4_grants", 64'(grantLog.size()), 64'(2));
    if (grantLog.size() == 2) checkOutput("t4_grant_order", 64'({grantLog[0], grantLog[1]}), 64'({32'd1, 32'd2}));
    if (outLog.size() == 7) begin
      checkOutput("t4_src1_end", 64'({outLog[3].beat.user, outLog[3].beat.last}), 64'({8'd1, 1'b1}));
      checkOutput("t4_src2_start", 64'(outLog[4].beat.user), 64'(2));
    end else checkOutput("t4_beats", 64'(outLog.size()), 64'(7));

    // Disabling arbitration mid-packet lets the packet finish but blocks new grants.
    doReset();
    addPacket(0, 4, 0);
    addPacket(1, 2, 0);
    step(0, 0);
    step(0, 0);
    cfg_arb_en = 1'b0;
    repeat (9) step(0, 0);
    checkOutput("t5_busy", 64'(arb_busy), 64'(0));
    checkOutput("t5_grants", 64'(grantLog.size()), 64'(1));
    checkOutput("t5_beats", 64'(outLog.size()), 64'(4));
    addPacket(0, 2, 0);
    cfg_arb_en = 1'b1;
    runUntilIdle(60, 0, 0);
    if (grantLog.size() == 3) checkOutput("t5_resume", 64'({grantLog[1], grantLog[2]}), 64'({32'd1, 32'd0}));
    else checkOutput("t5_grants_after", 64'(grantLog.size()), 64'(3));

    // Randomized traffic with gaps, backpressure and live cfg changes.
    doReset();
    total = 0;
    for (int p = 0; p < 24; p++) begin
      s = $urandom_range(0, NUM_SRC - 1);
      l = $urandom_range(1, 4);
      addPacket(s, l, 0);
      total += l;
    end
    for (int c = 0; c < 300; c++) begin
      cfg_arb_en   = ($urandom_range(0, 4) != 0);
      cfg_src_mask = NUM_SRC'($urandom);
      step(1, 1);
    end
    cfg_arb_en   = 1'b1;
    cfg_src_mask = '1;
    runUntilIdle(1000, 1, 1);
    checkOutput("rand_beats", 64'(outLog.size()), 64'(total));

`ifdef SDE_C2H_ARB_STATS_EN
    // Packet counter reads 7, then a clear coinciding with the 8th completion wins.
    doReset();
    repeat (7) addPacket(3, 2, 0);
    runUntilIdle(200, 0, 0);
    checkOutput("t6_cnt7", 64'(arb_src_pkt_cnt[3*32 +: 32]), 64'(7));
    addPacket(3, 2, 0);
    clrOnLast = 1'b1;
    runUntilIdle(50, 0, 0);
    clrOnLast = 1'b0;
    checkOutput("t6_cnt_clr", 64'(arb_src_pkt_cnt[3*32 +: 32]), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/sde_c2h_axis_arb.md
Name: sde_c2h_axis_arb

Overview:
- Packet-level round-robin arbiter that shares one C2H AXI-Stream channel (feeding the SDE C2H AXI-S input) among NUM_SRC CL stream sources.
- Grant is held for a whole packet, from the first beat through the beat with last=1; packets are never interleaved.
- A registered output stage decouples source muxing from downstream ready timing.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- AXIS_DATA_WIDTH, 512, tdata width in bits; keep width is AXIS_DATA_WIDTH/8.
- USER_BIT_WIDTH, 64, tuser width; 1 for compact-descriptor builds.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cfg_arb_en  in  1  0: no new grants; a packet in flight still completes.
- cfg_src_mask  in  NUM_SRC  1 = source eligible for grant; sampled only at arbitration.
- src_axis_valid  in  NUM_SRC  per-source valid.
- src_axis_data  in  NUM_SRC*AXIS_DATA_WIDTH  source i occupies slice [i*W +: W].
- src_axis_keep  in  NUM_SRC*AXIS_DATA_WIDTH/8  packed like data.
- src_axis_user  in  NUM_SRC*USER_BIT_WIDTH  packed like data.
- src_axis_last  in  NUM_SRC  per-source last.
- src_axis_ready  out  NUM_SRC  per-source ready; at most one bit is high at a time.
- c2h_axis_valid/data/keep/user/last  out  1/W/W/8/USER_BIT_WIDTH/1  merged stream to SDE.
- c2h_axis_ready  in  1  downstream ready.
- arb_busy  out  1  high in PKT state.
- arb_cur_src  out  $clog2(NUM_SRC)  index of the granted source; valid while arb_busy is high.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values:
  - state = IDLE; all src_axis_ready = 0; c2h_axis_valid = 0; arb_busy = 0; arb_cur_src = 0.
  - rr_ptr = NUM_SRC-1, so source 0 has first priority after reset.
  - Output data/keep/user/last registers are don't-care while c2h_axis_valid = 0.
- FSM IDLE -> PKT:
  - Condition: cfg_arb_en & |(src_axis_valid & cfg_src_mask).
  - Winner = first eligible index searching upward from rr_ptr+1, with modulo-NUM_SRC wrap.
  - Registers: arb_cur_src = winner, rr_ptr = winner, arb_busy = 1.
  - Arbitration costs one cycle. The earliest source beat is accepted the cycle after the grant.
- FSM PKT:
  - src_axis_ready[arb_cur_src] = out_ready_int, where out_ready_int = !c2h_axis_valid | c2h_axis_ready. All other ready bits = 0.
  - A beat is accepted when src valid & ready: it is loaded into the output register, and c2h_axis_valid <= 1.
  - If the output register holds a beat, c2h_axis_ready = 1, and no new beat is loaded, then c2h_axis_valid <= 0.
  - The accepted beat with last = 1 moves the FSM to IDLE next cycle. This gives one bubble per packet.
- Source side: a source that deasserts valid mid-packet stalls the channel. The grant is not released.
- cfg changes mid-packet: a change of cfg_src_mask or cfg_arb_en during PKT has no effect until the next IDLE.
- Latency: a source beat appears on c2h_axis_* one cycle after acceptance.
- Throughput: full rate within a packet while c2h_axis_ready = 1.
- Output stability: output is AXI-S compliant. Data and last hold stable while valid is high and ready is low.
- Single eligible source: it is re-granted after each packet with one idle cycle between packets.
- Reset mid-packet: the FSM aborts to IDLE and the output valid drops the next cycle. The partial packet is not resumed. Upstream must also be reset.

Optional Feature:
- Macro: SDE_C2H_ARB_STATS_EN.
- When defined, adds inputs and outputs:
  - cfg_clr_pkt_cnt (in, 1).
  - arb_src_pkt_cnt (out, NUM_SRC*32).
- Counter i increments on each accepted beat with last = 1 from source i, and wraps 0xFFFF_FFFF -> 0.
- cfg_clr_pkt_cnt clears all counters and has priority over a same-cycle increment. Reset value is 0.
- When undefined, these ports and counters are absent.

Decomposition:
- Package sde_c2h_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_PKT} arb_state_t.
  - Function rr_pick(req, ptr) returning the next index.
  - Constant SDE_C2H_ARB_MAX_SRC = 8.
- One sub-module, sde_axis_out_reg: the single-entry output register stage (valid/data/keep/user/last, with ready passthrough as described above).

Test Plan:
1. After reset, src0 and src2 are valid with 3-beat packets and mask=4'hF, c2h ready=1. Required: src0 is granted first; its beats appear on cycles 3-5; src2 follows after one bubble; arb_cur_src goes 0 then 2.
2. All 4 sources are continuously valid with 1-beat packets. Required: grant order 0,1,2,3,0; each source gets exactly 25% of packets over 40 packets.
3. c2h_axis_ready is toggled randomly during a 5-beat packet with data 0..4. Required: output sequence is exactly 0..4; data is stable while stalled; no duplicated or dropped beats.
4. mask=4'b1011 is set while src2 is valid. Required: src2 never receives ready. Mask flipped to 4'hF mid-packet of src1: src2 is granted only after src1's last beat.
5. cfg_arb_en=0 is asserted during the 2nd beat of a 4-beat packet. Required: the packet completes; no new grant follows; arb_busy=0. Re-enable resumes from rr_ptr+1.
6. STATS_EN: 7 packets from src3, then cfg_clr_pkt_cnt is pulsed in the same cycle as an 8th last beat. Required: count reads 7 before the pulse and 0 after it.
